phy_rx_link_ctrl: RTL



---
 rtl/phy_pkg.sv | 34 +++
 rtl/phy_lane_rr.sv | 43 ++++
 rtl/phy_rx_link_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared constants, state encoding and small helpers for the PHY receive
// link controller and its lane round-robin pointer.
package phy_pkg;

    // Link state encoding
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    // Special K-symbols on the byte stream
    localparam logic [7:0] K_COMMA = 8'hBC;
    localparam logic [7:0] K_IDLE  = 8'h7C;

    // Number of demux lanes fed round-robin
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        S_SEARCH = ST_SEARCH,
        S_ALIGN  = ST_ALIGN,
        S_ACTIVE = ST_ACTIVE
    } link_state_e;

    // 4-bit increment that sticks at 15 instead of wrapping
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'd15) begin
            r = 4'd15;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/phy_lane_rr.sv
// Round-robin lane pointer for the payload demux. Advances by one lane per
// payload byte and wraps after the last lane; clear has priority.
module phy_lane_rr
    import phy_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       adv,
    output logic [1:0] lane_o
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;

    // Next pointer: clear, advance with wrap, or hold
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = 2'd0;
        end else if (adv) begin
            if (ptr_q == 2'(LANES - 1)) begin
                ptr_d = 2'd0;
            end else begin
                ptr_d = ptr_q + 2'd1;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign lane_o = ptr_q;

endmodule

// File: rtl/phy_rx_link_ctrl.sv
// Receive-path link controller: comma-based sync acquisition, loss-of-sync
// detection (error run / keepalive expiry), comma/idle stripping and
// round-robin lane tagging of payload bytes. All outputs are registered.
module phy_rx_link_ctrl
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA     = K_COMMA,
    parameter logic [7:0] IDLE      = K_IDLE,
    parameter int         SYNC_CNT  = 4,
    parameter int         ERR_LIMIT = 3,
    parameter int         KEEPALIVE = 64
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_vld,
    input  logic       byte_err,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic [1:0] lane_o,
    output logic       active,
    output logic       idle_o,
    output logic       sync_lost,
    output logic [3:0] err_cnt_o
);

    localparam logic [3:0] SYNC_C = 4'(SYNC_CNT);
    localparam logic [3:0] ERR_C  = 4'(ERR_LIMIT);
    localparam logic [7:0] KA_C   = 8'(KEEPALIVE);

    link_state_e state_q, state_d;
    logic [3:0]  comma_cnt_q, comma_cnt_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  ka_cnt_q, ka_cnt_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic [1:0]  lane_q, lane_d;
    logic        active_q, active_d;
    logic        idle_q, idle_d;
    logic        sync_lost_q, sync_lost_d;

    logic        lane_clr_s;
    logic        lane_adv_s;
    logic [1:0]  lane_ptr_s;
    logic        clean_comma_s;
    logic        clean_idle_s;
    logic        lose_s;

    assign clean_comma_s = byte_vld && !byte_err && (byte_in == COMMA);
    assign clean_idle_s  = byte_vld && !byte_err && (byte_in == IDLE);

    phy_lane_rr u_lane_rr (
        .clk    (clk_4f),
        .reset  (reset),
        .clr    (lane_clr_s),
        .adv    (lane_adv_s),
        .lane_o (lane_ptr_s)
    );

    // Next-state, counter and output-register computation
    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        err_cnt_d   = err_cnt_q;
        ka_cnt_d    = ka_cnt_q;
        data_d      = data_q;
        lane_d      = lane_q;
        valid_d     = 1'b0;
        idle_d      = 1'b0;
        sync_lost_d = 1'b0;
        lane_clr_s  = 1'b0;
        lane_adv_s  = 1'b0;
        lose_s      = 1'b0;

        if (byte_vld) begin
            case (state_q)
                S_SEARCH: begin
                    err_cnt_d = 4'd0;
                    ka_cnt_d  = 8'd0;
                    if (clean_comma_s) begin
                        state_d     = S_ALIGN;
                        comma_cnt_d = 4'd1;
                    end else begin
                        comma_cnt_d = 4'd0;
                    end
                end
                S_ALIGN: begin
                    if (clean_comma_s) begin
                        if ((comma_cnt_q + 4'd1) >= SYNC_C) begin
                            // Sync achieved: start ACTIVE with fresh counters and lane 0
                            state_d     = S_ACTIVE;
                            comma_cnt_d = 4'd0;
                            err_cnt_d   = 4'd0;
                            ka_cnt_d    = 8'd0;
                            lane_clr_s  = 1'b1;
                        end else begin
                            comma_cnt_d = comma_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d     = S_SEARCH;
                        comma_cnt_d = 4'd0;
                    end
                end
                S_ACTIVE: begin
                    if (byte_err) begin
                        err_cnt_d = sat_inc4(err_cnt_q);
                        ka_cnt_d  = ka_cnt_q + 8'd1;
                    end else begin
                        err_cnt_d = 4'd0;
                        if (clean_comma_s) begin
                            idle_d   = 1'b1;
                            ka_cnt_d = 8'd0;
                        end else if (clean_idle_s) begin
                            idle_d   = 1'b1;
                            ka_cnt_d = ka_cnt_q + 8'd1;
                        end else begin
                            data_d     = byte_in;
                            valid_d    = 1'b1;
                            lane_d     = lane_ptr_s;
                            lane_adv_s = 1'b1;
                            ka_cnt_d   = ka_cnt_q + 8'd1;
                        end
                    end
                    // Either cause drops the link; a coincidence still yields one pulse
                    lose_s = (byte_err && (err_cnt_d >= ERR_C)) || (ka_cnt_d >= KA_C);
                    if (lose_s) begin
                        state_d     = S_SEARCH;
                        comma_cnt_d = 4'd0;
                        sync_lost_d = 1'b1;
                    end else begin
                        state_d = S_ACTIVE;
                    end
                end
                default: begin
                    state_d     = S_SEARCH;
                    comma_cnt_d = 4'd0;
                    err_cnt_d   = 4'd0;
                    ka_cnt_d    = 8'd0;
                end
            endcase
        end else begin
            // No byte: only the error count is forced to zero outside ACTIVE
            if (state_q != S_ACTIVE) begin
                err_cnt_d = 4'd0;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end

        active_d = (state_d == S_ACTIVE);
    end

    // State, counters and registered outputs with synchronous active-low reset
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_q     <= S_SEARCH;
            comma_cnt_q <= 4'd0;
            err_cnt_q   <= 4'd0;
            ka_cnt_q    <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            lane_q      <= 2'd0;
            active_q    <= 1'b0;
            idle_q      <= 1'b0;
            sync_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ka_cnt_q    <= ka_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            lane_q      <= lane_d;
            active_q    <= active_d;
            idle_q      <= idle_d;
            sync_lost_q <= sync_lost_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign lane_o    = lane_q;
    assign active    = active_q;
    assign idle_o    = idle_q;
    assign sync_lost = sync_lost_q;
    assign err_cnt_o = err_cnt_q;

endmodule
